ad_pingpong_buf: RTL
====================

# ad_pingpong_buf

ADC acquisition ping-pong buffer between the ADC sample front end and `cmd_decode`. Accepts samples while acquisition is enabled and writes them alternately into two banks of `AD_CHE_DATA_SIZE` words. When a bank fills, it pulses `ad_switch` and presents that bank to `cmd_decode` as a show-ahead read port stepped by `ad_rd`. Flags overruns when the writer completes a bank before the consumer has drained the previous one.

## Interface
- `AD_DATA_NBIT`, 16, sample and read-data width
- `BUF_DEPTH`, `` `AD_CHE_DATA_SIZE ``, words per bank; power of two, at least 4
- `AD_CHN_NBIT`, `` `AD_CHN_NBIT ``, channel select width
- `mclk`  in  1  main clock, 48 MHz; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ad_acq_en`  in  1  acquisition enable, driven by `cmd_decode`
- `ad_chn`  in  AD_CHN_NBIT  selected channel, driven by `cmd_decode`
- `adc_vd`  in  1  one-cycle sample strobe from the ADC front end
- `adc_data`  in  AD_DATA_NBIT  sample, qualified by `adc_vd`
- `ad_rd`  in  1  advance the read pointer by one word
- `ad_data`  out  AD_DATA_NBIT  current read word (show-ahead)
- `ad_switch`  out  1  one-cycle pulse: a bank is full and readable
- `ad_ovf`  out  1  sticky overrun flag

## Operation
- **Reset.** All outputs are 0. `wr_bank`=0, `rd_bank`=1, `wr_ptr`=0, `rd_ptr`=0, `rd_cnt`=BUF_DEPTH (the readable bank counts as drained).
- **Write FSM states:**
  - IDLE: waits for `ad_acq_en`.
  - FILL: on `ad_acq_en` rising, clear `ad_ovf` and `wr_ptr`, then enter FILL.
  - In FILL, each `adc_vd` writes `adc_data` to `{wr_bank, wr_ptr}` and increments `wr_ptr`.
- **Bank complete.** A write with `wr_ptr`=BUF_DEPTH-1 completes the bank:
  - `wr_ptr` wraps to 0.
  - `rd_bank` takes the old `wr_bank`, and `wr_bank` toggles.
  - `rd_ptr` and `rd_cnt` reset to 0.
  - `ad_switch` pulses.
  - If `rd_cnt` was below BUF_DEPTH at that moment, `ad_ovf` sets. The switch still occurs; newest data wins.
- **Stop.** `ad_acq_en` falling in FILL returns to IDLE. The partial bank is discarded, with no `ad_switch`; `rd_bank` stays readable.
- **Channel change.** `ad_chn` changing while in FILL restarts the bank: `wr_ptr` goes to 0, with no `ad_switch`. Mixed-channel banks never occur.
- **Read side.** `ad_data` always shows word `rd_ptr` of `rd_bank`.
  - `ad_rd` increments `rd_ptr` modulo BUF_DEPTH.
  - `ad_rd` increments `rd_cnt`, saturating at BUF_DEPTH.
- **Simultaneous events.**
  - `ad_rd` in the same cycle as a bank completion is ignored; the completion wins.
  - `adc_vd` in the same cycle as `ad_acq_en` rising is not written.
- **Widths.** `wr_ptr` and `rd_ptr` are log2(BUF_DEPTH) bits. `rd_cnt` is log2(BUF_DEPTH)+1 bits.

## Timing
- **Bank completion.** `ad_switch` is high in the cycle after the final write edge. In that same cycle `ad_data` already holds word 0 of the new `rd_bank`: the RAM read of address `{old wr_bank, 0}` is issued on the completing edge.
- **Read latency.** `ad_rd` high in cycle t gives `ad_data` = next word in cycle t+1. Back-to-back `ad_rd` streams one word per cycle.
- **Write latency.** A write is visible to the read port one cycle after its `adc_vd` edge.
- **`ad_ovf` timing.** `ad_ovf` sets in the same cycle as the `ad_switch` it flags. It clears only on `ad_acq_en` rising or on reset.
- **Reset mid-operation.** Reset asserted mid-operation takes effect immediately; all state returns to reset values. RAM contents are don't-care.

## Configuration
- `AD_BUF_TEST_PATTERN_EN` defined: the written word is a 16-bit running counter, reset 0, that increments on each accepted write. `adc_data` is ignored. The counter clears on `ad_acq_en` rising. Used for host-side link checking.
- Macro undefined: `adc_data` is written unchanged.

## Structure
- Shared constants stay in `globals.v`: `AD_DATA_NBIT`, `AD_CHN_NBIT`, `AD_CHE_DATA_SIZE`, `HIGH`, `LOW`. Add state codes `ST_BUF_IDLE` and `ST_BUF_FILL` there.
- One sub-module, `ad_buf_dpram`: simple dual-port RAM, 2×BUF_DEPTH words, one write port, one registered read port, clocked by `mclk`, no reset on the array.

## Test plan
Bench uses BUF_DEPTH=8.
- Reset, `ad_acq_en`=1, 8 strobes with data 0x0100..0x0107 → one `ad_switch` pulse after the 8th. `ad_data`=0x0100 in the pulse cycle. 7 consecutive `ad_rd` yield 0x0101..0x0107 on successive cycles. `ad_ovf`=0.
- Continue with 8 more samples 0x0200..0x0207 after a full drain → second `ad_switch`. Read-back shows the 0x02xx values from the other bank. `ad_ovf`=0.
- Third bank completes after only 3 `ad_rd` of the second → `ad_ovf`=1 in the `ad_switch` cycle. It stays 1 until `ad_acq_en` toggles 0→1, then reads 0.
- 5 samples, then `ad_acq_en`=0 → no `ad_switch`. Re-enable plus 8 samples → `ad_switch` after exactly 8. The 5 discarded samples never appear.
- `ad_chn` 0→3 after 4 samples → counting restarts, and `ad_switch` follows the 8th sample after the change. `ad_rd` in the completing cycle is ignored: `ad_data` equals word 0.
- With `AD_BUF_TEST_PATTERN_EN` and 16 samples of 0xFFFF → banks read 0x0000..0x0007, then 0x0008..0x000F. `rst_n` pulsed mid-bank → all outputs 0 immediately.

Source files
------------

// File: rtl/ad_pingpong_buf_pkg.sv
// Shared constants and write-FSM state codes for the ADC ping-pong buffer.
package ad_pingpong_buf_pkg;

  localparam int AD_DATA_NBIT     = 16;
  localparam int AD_CHN_NBIT      = 2;
  localparam int AD_CHE_DATA_SIZE = 256;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic {
    ST_BUF_IDLE = 1'b0,
    ST_BUF_FILL = 1'b1
  } buf_state_e;

endpackage

// File: rtl/ad_buf_dpram.sv
// Simple dual-port RAM holding both ping-pong banks: one write port and one
// registered read port. The array itself is not reset; only the read register is.
module ad_buf_dpram #(
  parameter int AD_DATA_NBIT = 16,
  parameter int ADDR_NBIT    = 4
) (
  input  logic                    mclk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_NBIT-1:0]    wr_addr,
  input  logic [AD_DATA_NBIT-1:0] wr_data,
  input  logic [ADDR_NBIT-1:0]    rd_addr,
  output logic [AD_DATA_NBIT-1:0] rd_data
);

  logic [AD_DATA_NBIT-1:0] mem [0:(2**ADDR_NBIT)-1];

  // Sample write port
  always_ff @(posedge mclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; cleared by reset so the output reads 0 immediately
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ad_pingpong_buf.sv
// ADC acquisition ping-pong buffer: samples fill one bank while the other bank
// is read show-ahead by the command decoder.
// Optional feature: define AD_BUF_TEST_PATTERN_EN to replace the written sample
// with a 16-bit running counter (adc_data ignored) for host-side link checking.
module ad_pingpong_buf
  import ad_pingpong_buf_pkg::*;
#(
  parameter int AD_DATA_NBIT = ad_pingpong_buf_pkg::AD_DATA_NBIT,
  parameter int BUF_DEPTH    = ad_pingpong_buf_pkg::AD_CHE_DATA_SIZE,
  parameter int AD_CHN_NBIT  = ad_pingpong_buf_pkg::AD_CHN_NBIT
) (
  input  logic                    mclk,
  input  logic                    rst_n,
  input  logic                    ad_acq_en,
  input  logic [AD_CHN_NBIT-1:0]  ad_chn,
  input  logic                    adc_vd,
  input  logic [AD_DATA_NBIT-1:0] adc_data,
  input  logic                    ad_rd,
  output logic [AD_DATA_NBIT-1:0] ad_data,
  output logic                    ad_switch,
  output logic                    ad_ovf
);

  localparam int             PW       = $clog2(BUF_DEPTH);
  localparam logic [PW-1:0]  PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [PW:0]    CNT_FULL = (PW + 1)'(BUF_DEPTH);

  buf_state_e state, state_nxt;

  logic                    acq_en_q;
  logic [AD_CHN_NBIT-1:0]  chn_q;
  logic                    wr_bank;
  logic                    rd_bank;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             rd_cnt;

  logic                    acq_rise;
  logic                    chn_chg;
  logic                    wr_en;
  logic                    bank_done;
  logic [PW-1:0]           rd_ptr_step;
  logic [PW:0]             wr_addr;
  logic [PW:0]             rd_addr;
  logic [AD_DATA_NBIT-1:0] wr_data;

  assign acq_rise  = ad_acq_en & ~acq_en_q;
  assign bank_done = wr_en & (wr_ptr == PTR_LAST);

  // Write FSM state register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BUF_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and write qualification; a channel change or the enable's rising
  // cycle never writes, so a bank only ever holds one channel's samples
  always_comb begin
    state_nxt = state;
    wr_en     = LOW;
    chn_chg   = LOW;
    case (state)
      ST_BUF_IDLE: begin
        if (acq_rise) begin
          state_nxt = ST_BUF_FILL;
        end
      end
      ST_BUF_FILL: begin
        if (!ad_acq_en) begin
          state_nxt = ST_BUF_IDLE;
        end else if (ad_chn != chn_q) begin
          chn_chg = HIGH;
        end else begin
          wr_en = adc_vd;
        end
      end
      default: state_nxt = ST_BUF_IDLE;
    endcase
  end

  // Write pointer, bank swap, switch pulse and sticky overrun flag
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      acq_en_q  <= LOW;
      chn_q     <= '0;
      wr_ptr    <= '0;
      wr_bank   <= LOW;
      rd_bank   <= HIGH;
      ad_switch <= LOW;
      ad_ovf    <= LOW;
    end else begin
      acq_en_q  <= ad_acq_en;
      chn_q     <= ad_chn;
      ad_switch <= bank_done;
      if (acq_rise) begin
        wr_ptr <= '0;
        ad_ovf <= LOW;
      end else if (chn_chg) begin
        wr_ptr <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (bank_done) begin
          rd_bank <= wr_bank;
          wr_bank <= ~wr_bank;
          if (rd_cnt < CNT_FULL) begin
            ad_ovf <= HIGH;
          end
        end
      end
    end
  end

  // Read pointer and drain count; a completing write overrides ad_rd
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      rd_cnt <= CNT_FULL;
    end else if (bank_done) begin
      rd_ptr <= '0;
      rd_cnt <= '0;
    end else if (ad_rd) begin
      rd_ptr <= rd_ptr + 1'b1;
      if (rd_cnt != CNT_FULL) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

`ifdef AD_BUF_TEST_PATTERN_EN
  logic [AD_DATA_NBIT-1:0] pat_cnt;

  // Running test-pattern counter, restarted with each acquisition
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      pat_cnt <= '0;
    end else if (acq_rise) begin
      pat_cnt <= '0;
    end else if (wr_en) begin
      pat_cnt <= pat_cnt + 1'b1;
    end
  end

  assign wr_data = pat_cnt;
`else
  assign wr_data = adc_data;
`endif

  // The read address looks one step ahead so the registered RAM output tracks
  // rd_ptr without extra latency; on completion it fetches word 0 of the new bank
  always_comb begin
    rd_ptr_step = ad_rd ? (rd_ptr + 1'b1) : rd_ptr;
    wr_addr     = {wr_bank, wr_ptr};
    if (bank_done) begin
      rd_addr = {wr_bank, {PW{1'b0}}};
    end else begin
      rd_addr = {rd_bank, rd_ptr_step};
    end
  end

  ad_buf_dpram #(
    .AD_DATA_NBIT (AD_DATA_NBIT),
    .ADDR_NBIT    (PW + 1)
  ) u_dpram (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ad_data)
  );

endmodule
